// File: rtl/systolic_sequencer.sv
// Job sequencer for an NxN output-stationary MAC grid: fetches K operand beats,
// skews them per lane onto the grid edges and frames the job with clear/enable/done.
module systolic_sequencer #(
   parameter int DATA_WIDTH = 32,
   parameter int N          = 3,
   parameter int K          = 3,
   parameter int ADDR_W     = ($clog2(K) > 1) ? $clog2(K) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  op_rd_en_o,
   output logic [ADDR_W-1:0]     op_addr_o,
   input  logic [N*DATA_WIDTH-1:0] a_col_i,
   input  logic [N*DATA_WIDTH-1:0] b_row_i,
   output logic [N*DATA_WIDTH-1:0] a_feed_o,
   output logic [N*DATA_WIDTH-1:0] b_feed_o,
   output logic                  mac_clr_o,
   output logic                  mac_en_o
);

   localparam int DW    = DATA_WIDTH;
   localparam int DRN_W = ($clog2(2 * N) > 1) ? $clog2(2 * N) : 1;
   localparam logic [ADDR_W-1:0] LAST_BEAT  = ADDR_W'(K - 1);
   localparam logic [DRN_W-1:0]  LAST_DRAIN = DRN_W'(2 * N - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FEED,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   beat_q, beat_d;
   logic [DRN_W-1:0]    drain_q, drain_d;

   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                rd_en_q, rd_en_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                clr_q, clr_d;
   logic                en_q, en_d;
   logic                rd_vld_q;

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      drain_d = drain_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            state_d = S_FEED;
            beat_d  = '0;
         end
         S_FEED: begin
            if (beat_q == LAST_BEAT) begin
               state_d = S_DRAIN;
               drain_d = '0;
            end else begin
               beat_d = beat_q + ADDR_W'(1);
            end
         end
         S_DRAIN: begin
            if (drain_q == LAST_DRAIN) begin
               state_d = S_DONE;
            end else begin
               drain_d = drain_q + DRN_W'(1);
            end
         end
         S_DONE: begin
            // A held start chains straight into the next job without an idle cycle.
            state_d = start_i ? S_CLEAR : S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so they are registered yet phase-aligned.
   always_comb begin
      busy_d  = (state_d == S_CLEAR) || (state_d == S_FEED) || (state_d == S_DRAIN);
      done_d  = (state_d == S_DONE);
      rd_en_d = (state_d == S_FEED);
      addr_d  = (state_d == S_FEED) ? beat_d : '0;
      clr_d   = (state_d == S_CLEAR);
      en_d    = (state_d == S_FEED) || (state_d == S_DRAIN);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         beat_q   <= '0;
         drain_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         rd_en_q  <= 1'b0;
         addr_q   <= '0;
         clr_q    <= 1'b0;
         en_q     <= 1'b0;
         rd_vld_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         beat_q   <= beat_d;
         drain_q  <= drain_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         rd_en_q  <= rd_en_d;
         addr_q   <= addr_d;
         clr_q    <= clr_d;
         en_q     <= en_d;
         rd_vld_q <= rd_en_q;
      end
   end

   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign op_rd_en_o = rd_en_q;
   assign op_addr_o  = addr_q;
   assign mac_clr_o  = clr_q;
   assign mac_en_o   = en_q;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_lane
         logic [DW-1:0] a_in;
         logic [DW-1:0] b_in;

         // Buffer data is only trusted the cycle after a read; otherwise inject zeros.
         assign a_in = rd_vld_q ? a_col_i[gi*DW +: DW] : '0;
         assign b_in = rd_vld_q ? b_row_i[gi*DW +: DW] : '0;

         if (gi == 0) begin : g_direct
            assign a_feed_o[gi*DW +: DW] = a_in;
            assign b_feed_o[gi*DW +: DW] = b_in;
         end else begin : g_skew
            logic [DW-1:0] a_sr_q [0:gi-1];
            logic [DW-1:0] b_sr_q [0:gi-1];

            always_ff @(posedge clk_i or negedge rst_ni) begin
               if (!rst_ni) begin
                  for (int m = 0; m < gi; m++) begin
                     a_sr_q[m] <= '0;
                     b_sr_q[m] <= '0;
                  end
               end else if (clr_q) begin
                  for (int m = 0; m < gi; m++) begin
                     a_sr_q[m] <= '0;
                     b_sr_q[m] <= '0;
                  end
               end else begin
                  a_sr_q[0] <= a_in;
                  b_sr_q[0] <= b_in;
                  for (int m = 1; m < gi; m++) begin
                     a_sr_q[m] <= a_sr_q[m-1];
                     b_sr_q[m] <= b_sr_q[m-1];
                  end
               end
            end

            assign a_feed_o[gi*DW +: DW] = a_sr_q[gi-1];
            assign b_feed_o[gi*DW +: DW] = b_sr_q[gi-1];
         end
      end
   endgenerate

endmodule

// File: tb/tb_systolic_sequencer.sv
// Scoreboard bench: jobs are modelled by their cycle offset from CLEAR, and a
// behavioural MAC grid turns the feeds into a product checked against plain matmul.
module tb_systolic_sequencer;

   localparam int DW = 32;
   localparam int N  = 3;
   localparam int K  = 3;
   localparam int AW = ($clog2(K) > 1) ? $clog2(K) : 1;
   localparam int JOB_LEN = 1 + K + 2 * N + 1;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic              busy, done, rd_en, mac_clr, mac_en;
   logic [AW-1:0]     op_addr;
   logic [N*DW-1:0]   a_col, b_row, a_feed, b_feed;

   systolic_sequencer #(.DATA_WIDTH(DW), .N(N), .K(K), .ADDR_W(AW)) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .start_i    (start),
      .busy_o     (busy),
      .done_o     (done),
      .op_rd_en_o (rd_en),
      .op_addr_o  (op_addr),
      .a_col_i    (a_col),
      .b_row_i    (b_row),
      .a_feed_o   (a_feed),
      .b_feed_o   (b_feed),
      .mac_clr_o  (mac_clr),
      .mac_en_o   (mac_en)
   );

   typedef struct packed {
      logic [31:0]       clr;
      logic [N*K*DW-1:0] a;
      logic [K*N*DW-1:0] b;
      logic [N*N*DW-1:0] c;
   } job_t;

   job_t          jobs_q[$];
   int            checks = 0;
   int            failures = 0;
   int            cyc = 0;
   int            last_done = -1;
   int            jobs_done = 0;
   bit            mon_en = 0;
   logic [DW-1:0] a_mem [N][K];
   logic [DW-1:0] b_mem [K][N];
   logic [DW-1:0] acc [N][N];
   logic [DW-1:0] ar  [N][N];
   logic [DW-1:0] br  [N][N];
   logic [DW-1:0] g_ain [N][N];
   logic [DW-1:0] g_bin [N][N];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Operand buffer: registered read, garbage on the bus when not reading.
   initial begin
      a_col = '0;
      b_row = '0;
      forever begin
         @(posedge clk);
         for (int i = 0; i < N; i++) begin
            if (rd_en) begin
               a_col[i*DW +: DW] <= a_mem[i][op_addr];
               b_row[i*DW +: DW] <= b_mem[op_addr][i];
            end else begin
               a_col[i*DW +: DW] <= $urandom();
               b_row[i*DW +: DW] <= $urandom();
            end
         end
      end
   end

   // Behavioural output-stationary grid: A moves right, B moves down.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            g_ain[i][j] = (j == 0) ? a_feed[i*DW +: DW] : ar[i][(j > 0) ? j - 1 : 0];
            g_bin[i][j] = (i == 0) ? b_feed[j*DW +: DW] : br[(i > 0) ? i - 1 : 0][j];
         end
      end
   end

   initial forever begin
      @(posedge clk or negedge rst_n);
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            if (!rst_n || mac_clr) begin
               acc[i][j] <= '0;
               ar[i][j]  <= '0;
               br[i][j]  <= '0;
            end else if (mac_en) begin
               acc[i][j] <= acc[i][j] + g_ain[i][j] * g_bin[i][j];
               ar[i][j]  <= g_ain[i][j];
               br[i][j]  <= g_bin[i][j];
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] a_val(input int mode, input int i, input int k);
      case (mode)
         1:       return (i == k) ? 1 : 0;
         2:       return 2;
         3:       return 10 * k + i;
         default: return $urandom_range(0, 255);
      endcase
   endfunction

   function automatic logic [DW-1:0] b_val(input int mode, input int k, input int j);
      case (mode)
         1:       return k * N + j + 1;
         2:       return 3;
         default: return $urandom_range(0, 255);
      endcase
   endfunction

   // One stimulus cycle; the model accepts start only when no job is running
   // or the running job is in its DONE cycle.
   task automatic step(input bit s, input int mode);
      job_t        j;
      logic [DW-1:0] sum;
      @(negedge clk);
      start = s;
      if (s && cyc >= last_done) begin
         j.clr = 32'(cyc + 1);
         for (int i = 0; i < N; i++)
            for (int k = 0; k < K; k++) begin
               a_mem[i][k] = a_val(mode, i, k);
               j.a[(i*K+k)*DW +: DW] = a_mem[i][k];
            end
         for (int k = 0; k < K; k++)
            for (int c = 0; c < N; c++) begin
               b_mem[k][c] = b_val(mode, k, c);
               j.b[(k*N+c)*DW +: DW] = b_mem[k][c];
            end
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
               sum = '0;
               for (int k = 0; k < K; k++) sum += a_mem[r][k] * b_mem[k][c];
               j.c[(r*N+c)*DW +: DW] = sum;
            end
         jobs_q.push_back(j);
         last_done = cyc + JOB_LEN;
      end
   endtask

   // Monitor: expected behaviour from the offset to the head job's CLEAR cycle.
   initial begin
      job_t           cur;
      int             o, kk;
      logic           e_busy, e_done, e_rd, e_clr, e_en;
      logic [AW-1:0]  e_addr;
      logic [N*DW-1:0] e_a, e_b;
      cur = '0;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            o = -1;
            if (jobs_q.size() > 0) begin
               cur = jobs_q[0];
               o = cyc - int'(cur.clr);
            end
            e_clr  = (o == 0);
            e_rd   = (o >= 1) && (o <= K);
            e_en   = (o >= 1) && (o <= K + 2 * N);
            e_busy = (o >= 0) && (o <= K + 2 * N);
            e_done = (o == K + 2 * N + 1);
            e_addr = e_rd ? AW'(o - 1) : '0;
            e_a = '0;
            e_b = '0;
            for (int i = 0; i < N; i++) begin
               kk = o - 2 - i;
               if (o >= 0 && kk >= 0 && kk < K) begin
                  e_a[i*DW +: DW] = cur.a[(i*K+kk)*DW +: DW];
                  e_b[i*DW +: DW] = cur.b[(kk*N+i)*DW +: DW];
               end
            end
            chk("ctrl", {busy, done, rd_en, mac_clr, mac_en, (e_rd ? op_addr : AW'(0))},
                {e_busy, e_done, e_rd, e_clr, e_en, e_addr});
            chk("a_feed", a_feed, e_a);
            chk("b_feed", b_feed, e_b);
            if (e_done) begin
               for (int r = 0; r < N; r++)
                  for (int c = 0; c < N; c++)
                     chk($sformatf("C[%0d][%0d]", r, c), acc[r][c], cur.c[(r*N+c)*DW +: DW]);
               jobs_done++;
               $display("job %0d clr=%0d done=%0d C00=%0d C11=%0d C22=%0d", jobs_done,
                        cur.clr, cyc, acc[0][0], acc[1][1], acc[N-1][N-1]);
               void'(jobs_q.pop_front());
            end
         end
      end
   end

   initial begin
      int done_seen;
      rst_n = 1'b0;
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ctrl", {busy, done, rd_en, mac_clr, mac_en, op_addr}, '0);
      chk("rst_a_feed", a_feed, '0);
      chk("rst_b_feed", b_feed, '0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_ctrl", {busy, done, rd_en, mac_clr, mac_en, op_addr}, '0);
      mon_en = 1'b1;

      // Identity A, B = 1..9: C must reproduce B.
      step(1, 1);
      repeat (12) step(0, 0);
      // Skew pattern on A.
      step(1, 3);
      repeat (12) step(0, 0);
      // All-2 by all-3, run twice back to back: every element 18 both times.
      repeat (2 * JOB_LEN) step(1, 2);
      repeat (12) step(0, 0);
      // Start pulses inside FEED and DRAIN must be ignored.
      step(1, 0);
      for (int c = 0; c < JOB_LEN - 1; c++) step(c == 3 || c == 7, 0);
      repeat (12) step(0, 0);
      // Start held for three jobs.
      repeat (3 * JOB_LEN) step(1, 0);
      repeat (12) step(0, 0);
      // Random start traffic.
      repeat (400) step($urandom_range(0, 3) == 0, 0);
      repeat (15) step(0, 0);
      chk("jobs_pending", 512'(jobs_q.size()), '0);

      // Reset in the middle of FEED discards the job.
      step(1, 0);
      step(0, 0);
      step(0, 0);
      #1;
      mon_en = 1'b0;
      rst_n  = 1'b0;
      @(negedge clk);
      chk("midrst_ctrl", {busy, done, rd_en, mac_clr, mac_en}, '0);
      chk("midrst_a_feed", a_feed, '0);
      chk("midrst_b_feed", b_feed, '0);
      jobs_q.delete();
      last_done = -1;
      @(negedge clk);
      rst_n = 1'b1;
      done_seen = 0;
      repeat (JOB_LEN + 4) begin
         @(negedge clk);
         if (done || busy) done_seen++;
      end
      chk("midrst_no_done", 512'(done_seen), '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
